// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
//
// Issuer and result-capture controller for an external combinational ALU.
// A request is accepted over a valid/ready handshake, its operands are
// registered and driven onto the ALU lines for one EXEC cycle, and the ALU
// result plus N/Z/C/V flags are captured at the end of that cycle. The
// captured values are then offered over a valid/ready response handshake.
// An architectural NZCV register is kept (updated only when the request asks
// for it) and a 4-bit condition code is evaluated against it.
//
// Optional build feature (macro ALU_EXEC_CTRL_PIPE_EN):
//   When defined, a new request may be accepted in the same edge that
//   completes the current response (req_ready follows rsp_ready in RESP),
//   giving a 2-cycle issue interval. When undefined, requests are accepted
//   only in IDLE (3-cycle issue interval).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_op, req_a, req_b      ALU select and operands
//   req_use_carry             carry-in = stored C flag (else 0)
//   req_set_flags             load NZCV with this op's flags
//   alu_a, alu_b, alu_ci,
//   alu_sel                   registered drive to the ALU
//   alu_result, alu_n/z/c/v   combinational ALU outputs
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_flags     captured result and {N,Z,C,V} of this op
//   nzcv                      architectural flags {N,Z,C,V}
//   cond, cond_pass           condition code and its evaluation vs nzcv
// ---------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_carry,
  input  logic             req_set_flags,
  // ALU drive
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic [SEL_W-1:0] alu_sel,
  // ALU return
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  // flags and condition evaluation
  output logic [3:0]       nzcv,
  input  logic [3:0]       cond,
  output logic             cond_pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Condition-code evaluation against a {N,Z,C,V} vector.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'h0:    r = z;                    // EQ
      4'h1:    r = ~z;                   // NE
      4'h2:    r = c;                    // CS
      4'h3:    r = ~c;                   // CC
      4'h4:    r = n;                    // MI
      4'h5:    r = ~n;                   // PL
      4'h6:    r = v;                    // VS
      4'h7:    r = ~v;                   // VC
      4'h8:    r = c & ~z;               // HI
      4'h9:    r = ~c | z;               // LS
      4'hA:    r = (n == v);             // GE
      4'hB:    r = (n != v);             // LT
      4'hC:    r = ~z & (n == v);        // GT
      4'hD:    r = z | (n != v);         // LE
      4'hE:    r = 1'b1;                 // AL
      4'hF:    r = 1'b0;                 // NV
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e             state_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [SEL_W-1:0]   alu_sel_q;
  logic               alu_ci_q;
  logic               set_flags_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [3:0]         rsp_flags_q;
  logic [3:0]         nzcv_q;

  logic               req_ready_s;
  logic               accept_s;
  logic               ci_d;
  logic [3:0]         alu_flags_s;

  // Handshake decode: ready depends only on state (and rsp_ready when the
  // pipelined completion path is built in).
  always_comb begin
    req_ready_s = 1'b0;
    case (state_q)
      S_IDLE:  req_ready_s = 1'b1;
`ifdef ALU_EXEC_CTRL_PIPE_EN
      S_RESP:  req_ready_s = rsp_ready;
`else
      S_RESP:  req_ready_s = 1'b0;
`endif
      S_EXEC:  req_ready_s = 1'b0;
      default: req_ready_s = 1'b0;
    endcase
    accept_s = req_valid & req_ready_s;
    // Carry-in is frozen at acceptance from the flags as they stand then;
    // any earlier set_flags op has already written nzcv_q by this point.
    if (req_use_carry) begin
      ci_d = nzcv_q[1];
    end else begin
      ci_d = 1'b0;
    end
    alu_flags_s = {alu_n, alu_z, alu_c, alu_v};
  end

  // Control FSM with operand, response and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      alu_a_q      <= {WIDTH{1'b0}};
      alu_b_q      <= {WIDTH{1'b0}};
      alu_sel_q    <= {SEL_W{1'b0}};
      alu_ci_q     <= 1'b0;
      set_flags_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_flags_q  <= 4'b0000;
      nzcv_q       <= 4'b0000;
    end else begin
      // Operand registers only move on acceptance, so the ALU lines hold
      // their last values in every other cycle.
      if (accept_s) begin
        alu_a_q     <= req_a;
        alu_b_q     <= req_b;
        alu_sel_q   <= req_op;
        alu_ci_q    <= ci_d;
        set_flags_q <= req_set_flags;
      end

      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags_s;
          if (set_flags_q) begin
            nzcv_q <= alu_flags_s;
          end
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // accept_s can only be set here in the pipelined build.
            if (accept_s) begin
              state_q <= S_EXEC;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_ci     = alu_ci_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign nzcv       = nzcv_q;
  assign cond_pass  = cond_eval(cond, nzcv_q);

endmodule
